// File: rtl/mem_arbiter.sv
// Round-robin arbiter between the processor pool and the shared single-port data memory.
// One transaction at a time: IDLE picks a winner, ISSUE drives the command, RD_WAIT returns read data.
module mem_arbiter #(
    parameter int PROC_COUNT = 4,
    parameter int BUS_W      = 256,
    parameter int WORD_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int MEM_LAT    = 2,
    localparam int LANES     = BUS_W / WORD_W
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic [PROC_COUNT-1:0] i_req_rd,
    input  logic [PROC_COUNT-1:0] i_req_wr,
    input  logic [ADDR_W-1:0]     i_addr    [PROC_COUNT],
    input  logic [BUS_W-1:0]      i_data    [PROC_COUNT],
    input  logic [2:0]            i_wr_size [PROC_COUNT],
    output logic [PROC_COUNT-1:0] o_grant_rd,
    output logic [PROC_COUNT-1:0] o_grant_wr,
    output logic [PROC_COUNT-1:0] o_valid,
    output logic [BUS_W-1:0]      o_data,
    output logic                  m_rd_en,
    output logic                  m_wr_en,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [BUS_W-1:0]      m_wdata,
    output logic [LANES-1:0]      m_wmask,
    input  logic [BUS_W-1:0]      m_rdata
);

    localparam int PW = (PROC_COUNT > 1) ? $clog2(PROC_COUNT) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] RD_WAIT = 2'd2;

    logic [1:0]            state;
    logic [PW-1:0]         ptr;
    logic [PW-1:0]         sel;
    logic                  is_wr;
    logic [ADDR_W-1:0]     lat_addr;
    logic [BUS_W-1:0]      lat_data;
    logic [2:0]            lat_size;
    logic [3:0]            cnt;
    logic [BUS_W-1:0]      data_q;

    logic [PROC_COUNT-1:0] req;
    logic                  found;
    logic [PW-1:0]         win;
    logic [PW-1:0]         idx;
    logic [LANES-1:0]      mask;
    logic                  rd_done;

    assign req     = i_req_rd | i_req_wr;
    assign rd_done = (state == RD_WAIT) && (cnt == 4'd0);

    // First requester at or after ptr, wrapping around the pool.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned i = 0; i < PROC_COUNT; i++) begin
            idx = PW'((32'(ptr) + i) % PROC_COUNT);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        mask = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            mask[k] = (k <= 32'(lat_size));
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state    <= IDLE;
            ptr      <= '0;
            sel      <= '0;
            is_wr    <= 1'b0;
            lat_addr <= '0;
            lat_data <= '0;
            lat_size <= '0;
            cnt      <= '0;
            data_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        sel      <= win;
                        is_wr    <= i_req_wr[win];  // write wins when both are raised
                        lat_addr <= i_addr[win];
                        lat_data <= i_data[win];
                        lat_size <= i_wr_size[win];
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    ptr <= (sel == PW'(PROC_COUNT - 1)) ? '0 : sel + 1'b1;
                    if (is_wr) begin
                        state <= IDLE;
                    end else begin
                        state <= RD_WAIT;
                        cnt   <= 4'(MEM_LAT - 1);
                    end
                end
                RD_WAIT: begin
                    if (cnt == 4'd0) begin
                        data_q <= m_rdata;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode from state so grants and strobes are one cycle wide by construction.
    always_comb begin
        o_grant_rd = '0;
        o_grant_wr = '0;
        o_valid    = '0;
        o_data     = data_q;
        m_rd_en    = 1'b0;
        m_wr_en    = 1'b0;
        m_addr     = '0;
        m_wdata    = '0;
        m_wmask    = '0;
        if (state == ISSUE) begin
            m_addr = lat_addr;
            if (is_wr) begin
                o_grant_wr[sel] = 1'b1;
                m_wr_en         = 1'b1;
                m_wdata         = lat_data;
                m_wmask         = mask;
            end else begin
                o_grant_rd[sel] = 1'b1;
                m_rd_en         = 1'b1;
            end
        end
        if (rd_done) begin
            o_valid[sel] = 1'b1;
            o_data       = m_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: vector table plus directed round-robin, read+write and reset sequences.
// Expected grants/valids go into a scoreboard queue at stimulus time and are popped by a monitor.
module tb_mem_arbiter;

    localparam int P  = 4;
    localparam int BW = 256;
    localparam int WW = 32;
    localparam int AW = 32;
    localparam int ML = 2;
    localparam int L  = BW / WW;

    logic          clk = 1'b0;
    logic          rstn;
    logic [P-1:0]  req_rd, req_wr;
    logic [AW-1:0] addr [P];
    logic [BW-1:0] data [P];
    logic [2:0]    size [P];
    logic [P-1:0]  gr, gw, v;
    logic [BW-1:0] o_data;
    logic          m_rd_en, m_wr_en;
    logic [AW-1:0] m_addr;
    logic [BW-1:0] m_wdata;
    logic [L-1:0]  m_wmask;
    logic [BW-1:0] m_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.PROC_COUNT(P), .BUS_W(BW), .WORD_W(WW), .ADDR_W(AW), .MEM_LAT(ML)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_req_rd(req_rd), .i_req_wr(req_wr),
        .i_addr(addr), .i_data(data), .i_wr_size(size),
        .o_grant_rd(gr), .o_grant_wr(gw), .o_valid(v), .o_data(o_data),
        .m_rd_en(m_rd_en), .m_wr_en(m_wr_en), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wmask(m_wmask), .m_rdata(m_rdata)
    );

    // Memory model: read data appears exactly ML cycles after the m_rd_en cycle, zero otherwise.
    logic [BW-1:0] pipe [ML];
    logic [31:0]   mem_word;
    always @(posedge clk) begin
        if (!rstn) begin
            for (int j = 0; j < ML; j++) pipe[j] <= '0;
        end else begin
            pipe[0] <= m_rd_en ? {{7{m_addr}}, mem_word} : '0;
            for (int j = 1; j < ML; j++) pipe[j] <= pipe[j-1];
        end
    end
    assign m_rdata = pipe[ML-1];

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // kind: 0 write grant, 1 read grant, 2 read valid
    typedef struct {
        int            kind;
        int            proc;
        logic [AW-1:0] addr;
        logic [BW-1:0] data;
        logic [L-1:0]  mask;
    } ev_t;
    ev_t sbq[$];
    ev_t ev_mon;

    task automatic push_ev(input int kind, input int proc, input logic [AW-1:0] a,
                           input logic [BW-1:0] d, input logic [L-1:0] m);
        ev_t e;
        e.kind = kind; e.proc = proc; e.addr = a; e.data = d; e.mask = m;
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        logic [P-1:0] oh;
        if (rstn && (|gw || |gr || |v)) begin
            if (sbq.size() == 0) begin
                check("unexpected_event", {gw, gr, v}, '0);
            end else begin
                ev_mon = sbq.pop_front();
                oh = P'(1) << ev_mon.proc;
                case (ev_mon.kind)
                    0: begin
                        check("wr_grant", {gw, gr, v}, {oh, {P{1'b0}}, {P{1'b0}}});
                        check("wr_addr", m_addr, ev_mon.addr);
                        check("wr_data", m_wdata, ev_mon.data);
                        check("wr_mask", m_wmask, ev_mon.mask);
                        check("wr_strobes", {m_wr_en, m_rd_en}, 2'b10);
                    end
                    1: begin
                        check("rd_grant", {gw, gr, v}, {{P{1'b0}}, oh, {P{1'b0}}});
                        check("rd_addr", m_addr, ev_mon.addr);
                        check("rd_strobes", {m_wr_en, m_rd_en, m_wmask}, {2'b01, {L{1'b0}}});
                    end
                    default: begin
                        check("rd_valid", {gw, gr, v}, {{P{1'b0}}, {P{1'b0}}, oh});
                        check("rd_data", o_data, ev_mon.data);
                    end
                endcase
            end
        end
    end

    task automatic wait_grant(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!(|gw || |gr) && n < 20);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!(|v) && n < 20);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, {gw, gr, v, m_rd_en, m_wr_en, m_wmask, m_addr}, '0);
        check({tag, "_odata"}, o_data, '0);
        check({tag, "_wdata"}, m_wdata, '0);
    endtask

    typedef struct {
        int            proc;
        bit            wr;
        logic [AW-1:0] addr;
        logic [2:0]    size;
        logic [BW-1:0] data;
        logic [L-1:0]  mask;
        logic [31:0]   rword;
    } vec_t;
    vec_t vecs [7];

    initial begin : main
        int n;
        int last;
        rstn = 1'b0; req_rd = '0; req_wr = '0; mem_word = '0;
        for (int i = 0; i < P; i++) begin addr[i] = '0; data[i] = '0; size[i] = '0; end

        vecs[0] = '{2, 1'b1, 32'h40,   3'd3, {8{32'hA1A2_A3A4}}, 8'h0F, 32'h0};
        vecs[1] = '{1, 1'b0, 32'h80,   3'd0, '0,                 8'h00, 32'h0000_DEAD};
        vecs[2] = '{3, 1'b1, 32'h1C0,  3'd7, {8{32'h1357_9BDF}}, 8'hFF, 32'h0};
        vecs[3] = '{0, 1'b1, 32'h200,  3'd0, {8{32'h0F0F_F0F0}}, 8'h01, 32'h0};
        vecs[4] = '{0, 1'b0, 32'h244,  3'd5, '0,                 8'h00, 32'hCAFE_0001};
        vecs[5] = '{3, 1'b0, 32'h3F0,  3'd2, '0,                 8'h00, 32'h0BAD_F00D};
        vecs[6] = '{1, 1'b1, 32'h500,  3'd6, {8{32'h8765_4321}}, 8'h7F, 32'h0};

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rstn = 1'b1;

        foreach (vecs[k]) begin
            @(negedge clk);
            addr[vecs[k].proc] = vecs[k].addr;
            data[vecs[k].proc] = vecs[k].data;
            size[vecs[k].proc] = vecs[k].size;
            mem_word = vecs[k].rword;
            if (vecs[k].wr) begin
                req_wr[vecs[k].proc] = 1'b1;
                push_ev(0, vecs[k].proc, vecs[k].addr, vecs[k].data, vecs[k].mask);
            end else begin
                req_rd[vecs[k].proc] = 1'b1;
                push_ev(1, vecs[k].proc, vecs[k].addr, '0, '0);
                push_ev(2, vecs[k].proc, '0, {{7{vecs[k].addr}}, vecs[k].rword}, '0);
            end
            wait_grant(n);
            check("grant_latency", n, 1);
            req_wr = '0; req_rd = '0;
            if (!vecs[k].wr) begin
                wait_valid(n);
                check("valid_latency", n, ML);
            end
            @(negedge clk);
        end

        // Round-robin from ptr=0; proc 0 re-raises while 1 is granted and must queue behind 3.
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < P; i++) begin
            addr[i] = 32'h100 + 32'(i) * 4;
            data[i] = {8{32'(i + 1) * 32'h1111_1111}};
            size[i] = 3'd7;
        end
        req_wr = '1;
        for (int i = 0; i < P; i++) push_ev(0, i, 32'h100 + 32'(i) * 4, {8{32'(i + 1) * 32'h1111_1111}}, 8'hFF);
        push_ev(0, 0, 32'h100, {8{32'h1111_1111}}, 8'hFF);
        last = 0;
        for (int k = 0; k < 5; k++) begin
            wait_grant(n);
            if (k > 0) check("rr_spacing", n, 2);
            req_wr = req_wr & ~gw;
            if (k == 1) req_wr[0] = 1'b1;
        end
        @(negedge clk);

        // Same processor raises read and write: write first, read on the next arbitration.
        addr[0] = 32'h600; data[0] = {8{32'h5A5A_0600}}; size[0] = 3'd1; mem_word = 32'h7777_0600;
        req_wr[0] = 1'b1; req_rd[0] = 1'b1;
        push_ev(0, 0, 32'h600, {8{32'h5A5A_0600}}, 8'h03);
        push_ev(1, 0, 32'h600, '0, '0);
        push_ev(2, 0, '0, {{7{32'h600}}, 32'h7777_0600}, '0);
        wait_grant(n);
        check("rw_wr_first", gw, 4'b0001);
        req_wr[0] = 1'b0;
        wait_grant(n);
        check("rw_rd_spacing", n, 2);
        req_rd[0] = 1'b0;
        wait_valid(n);
        check("rw_valid_latency", n, ML);
        @(negedge clk);

        // Reset during RD_WAIT: everything clears, the read is dropped, ptr returns to 0.
        addr[2] = 32'h700; mem_word = 32'h1234_5678;
        req_rd[2] = 1'b1;
        push_ev(1, 2, 32'h700, '0, '0);
        wait_grant(n);
        req_rd = '0;
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check_all_zero("midread_reset");
        rstn = 1'b1;
        repeat (ML + 2) @(negedge clk);
        addr[3] = 32'h800; data[3] = {8{32'h3333_0800}}; size[3] = 3'd4;
        addr[0] = 32'h900; data[0] = {8{32'h0000_0900}}; size[0] = 3'd7;
        req_wr[3] = 1'b1; req_wr[0] = 1'b1;
        push_ev(0, 0, 32'h900, {8{32'h0000_0900}}, 8'hFF);
        push_ev(0, 3, 32'h800, {8{32'h3333_0800}}, 8'h1F);
        wait_grant(n);
        req_wr = req_wr & ~gw;
        wait_grant(n);
        check("ptr_reset_spacing", n, 2);
        req_wr = '0;

        repeat (4) @(negedge clk);
        check("scoreboard_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the processor pool and upstream of the shared single-port data memory.
- Takes the per-processor read/write requests, addresses, write data and write sizes.
- Picks one requester at a time, round-robin, and drives the memory command.
- Returns one-cycle grant pulses, shared read data and a per-processor valid strobe to the pool.

Parameters:
- PROC_COUNT, 4, number of processors arbitrated.
- BUS_W, 256, data bus width in bits.
- WORD_W, 32, lane width; LANES = BUS_W/WORD_W (8 at defaults; must be ≤ 8).
- ADDR_W, 32, address width.
- MEM_LAT, 2, memory read latency in cycles from m_rd_en to m_rdata valid; legal range 1..15.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rstn  in  1  reset, synchronous, active-low.
- i_req_rd  in  PROC_COUNT  per-processor read request, held until granted.
- i_req_wr  in  PROC_COUNT  per-processor write request, held until granted.
- i_addr  in  PROC_COUNT x ADDR_W  per-processor address (unpacked array).
- i_data  in  PROC_COUNT x BUS_W  per-processor write data (unpacked array).
- i_wr_size  in  PROC_COUNT x 3  per-processor write size; value N means lanes 0..N written.
- o_grant_rd  out  PROC_COUNT  one-hot read grant pulse.
- o_grant_wr  out  PROC_COUNT  one-hot write grant pulse.
- o_valid  out  PROC_COUNT  one-hot read-data-valid pulse.
- o_data  out  BUS_W  read data shared by all processors; qualified only by o_valid.
- m_rd_en  out  1  memory read strobe.
- m_wr_en  out  1  memory write strobe.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  BUS_W  memory write data.
- m_wmask  out  LANES  per-lane write enable.
- m_rdata  in  BUS_W  memory read data, valid MEM_LAT cycles after m_rd_en.

Behaviour:
- Reset (i_rstn=0 at an edge):
  - State goes to IDLE and the round-robin pointer ptr goes to 0.
  - All outputs go to 0: grants, o_valid, o_data, m_rd_en, m_wr_en, m_addr, m_wdata, m_wmask.
  - Reset mid-read abandons the transaction; the pending m_rdata is ignored and no o_valid is issued.
- Requests: req[i] = i_req_rd[i] | i_req_wr[i]. If both are high for the same processor, the write is served first; the read stays pending.
- States: IDLE, ISSUE, RD_WAIT.
- IDLE:
  - If any req is high at edge T, the winner w is the first set bit searching ptr, ptr+1, ... with wrap modulo PROC_COUNT.
  - At T the block latches w, the operation type, i_addr[w], i_data[w] and i_wr_size[w], then moves to ISSUE.
  - If no req is high, it stays in IDLE.
- ISSUE (cycle T+1, exactly one cycle):
  - Asserts o_grant_wr[w] or o_grant_rd[w].
  - Drives m_addr from the latch; for a write also m_wdata, m_wmask and m_wr_en=1; for a read m_rd_en=1.
  - Sets ptr = (w+1) mod PROC_COUNT.
  - A write goes to IDLE; a read goes to RD_WAIT.
  - The granted processor must drop that request at the T+1 edge; IDLE at T+2 may arbitrate again.
- RD_WAIT:
  - A counter is loaded with MEM_LAT-1 at entry.
  - When the counter reaches 0, the cycle is T+1+MEM_LAT. In that cycle m_rdata passes combinationally to o_data, o_valid[w] is asserted for one cycle, and the next state is IDLE.
  - o_data holds its last value otherwise.
- Latency:
  - Write: grant appears 1 cycle after the request is sampled; the next arbitration is 2 cycles after sampling.
  - Read: data appears MEM_LAT+1 cycles after the request is sampled.
- Mask: m_wmask lane k = (k ≤ N). N ≥ LANES-1 gives all lanes. m_wmask = 0 for reads and when idle.
- Strobes: m_rd_en and m_wr_en are never both high. At most one bit is set across all grant and valid outputs in any cycle.
- Requests arriving while ISSUE or RD_WAIT is active are only evaluated on the return to IDLE; none are lost, since requests are level-held.

Test Plan:
- Single write:
  - Stimulus: i_req_wr[2]=1, i_addr[2]=0x40, i_wr_size[2]=3, ptr=0.
  - Required response: next cycle o_grant_wr=4'b0100, m_wr_en=1, m_addr=0x40, m_wmask=8'h0F; back to IDLE the following cycle.
- Single read, MEM_LAT=2:
  - Stimulus: i_req_rd[1]=1 at edge T, addr 0x80; memory returns 0xDEAD at T+3.
  - Required response: o_grant_rd=4'b0010 and m_rd_en=1 at T+1; o_valid=4'b0010 and o_data=0xDEAD at T+3.
- Round-robin:
  - Stimulus: all four processors hold write requests, each dropping it after its grant.
  - Required response: grants occur in the order 0,1,2,3, spaced 2 cycles apart. A re-raised req[0] before req[3] is served must still wait behind 3.
- Read+write from the same processor:
  - Stimulus: i_req_rd[0]=i_req_wr[0]=1.
  - Required response: write granted first, then read granted on the next arbitration; the read gets o_valid.
- Reset mid-read:
  - Stimulus: i_rstn=0 during RD_WAIT.
  - Required response: all outputs 0 the next cycle; no o_valid for the abandoned read; ptr=0.
- Full-width write:
  - Stimulus: i_wr_size=7.
  - Required response: m_wmask=8'hFF and m_wdata equal to i_data[w].
